// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller that owns an NREG x DATA_W register file and
// sequences an external combinational ALU. Each accepted request walks
// IDLE -> DECODE -> EXEC -> WB, one cycle per state. The result is written
// back and the Z/N/C status flags are updated on the way out of WB.
// INC, DEC, SWAP and the unsigned compares are built here from native ALU
// operations (or no ALU use at all).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while IDLE
//   req_op/req_rd/req_rs  opcode, destination/operand-A index, operand-B index
//   alu_instr/alu_a/alu_b registered drive to the ALU; held outside EXEC
//   alu_result/alu_carry  combinational ALU response, sampled at end of EXEC
//   done, err             one-cycle retire pulse, err flags an illegal opcode
//   flag_z/flag_n/flag_c  status flags
//   dbg_addr/dbg_data     combinational register-file read port
//
// state  | meaning
// IDLE   | ready for a request; latch op/rd/rs on accept
// DECODE | read operands, remap opcode, load ALU drive registers
// EXEC   | ALU operates; sample result and carry at end of cycle
// WB     | done pulse; register/flag update at end of cycle
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_W = 20,
    parameter int OP_W   = 14,
    parameter int NREG   = 8,
    localparam int IW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [IW-1:0]     req_rd,
    input  logic [IW-1:0]     req_rs,
    output logic [OP_W-1:0]   alu_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    input  logic [IW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [OP_W-1:0] OP_NOT  = OP_W'('h0A7);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'('h0D1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'('h0BC);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'('h0E6);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'('h0FB);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'('h110);
    localparam logic [OP_W-1:0] OP_ROTR = OP_W'('h125);
    localparam logic [OP_W-1:0] OP_ROTL = OP_W'('h13A);
    localparam logic [OP_W-1:0] OP_SWAP = OP_W'('h14F);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'('h164);
    localparam logic [OP_W-1:0] OP_DEC  = OP_W'('h179);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'('h18E);
    localparam logic [OP_W-1:0] OP_ADDC = OP_W'('h1A3);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'('h1B8);
    localparam logic [OP_W-1:0] OP_SUBC = OP_W'('h1CD);
    localparam logic [OP_W-1:0] OP_EQ   = OP_W'('h1E2);
    localparam logic [OP_W-1:0] OP_GT   = OP_W'('h1F7);
    localparam logic [OP_W-1:0] OP_LT   = OP_W'('h20C);
    localparam logic [OP_W-1:0] OP_GET  = OP_W'('h221);
    localparam logic [OP_W-1:0] OP_LET  = OP_W'('h236);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    // Writeback class of the current operation
    typedef enum logic [1:0] {
        CLS_WR   = 2'd0,
        CLS_SWAP = 2'd1,
        CLS_CMP  = 2'd2,
        CLS_ILL  = 2'd3
    } cls_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] rf [NREG];
    logic [OP_W-1:0]   op_q;
    logic [IW-1:0]     rd_q;
    logic [IW-1:0]     rs_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              cy_q;
    cls_t              cls_q;
    logic              cupd_q;

    logic [OP_W-1:0]   dec_instr;
    logic              dec_b_one;
    logic              dec_cupd;
    cls_t              dec_cls;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                done      = 1'b1;
                err       = (cls_q == CLS_ILL);
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Opcode remap: INC/DEC become ADD/SUB with B forced to 1, compares
    // run as SUB so the ALU sees a legal instruction.
    always_comb begin
        dec_instr = op_q;
        dec_b_one = 1'b0;
        dec_cupd  = 1'b0;
        dec_cls   = CLS_WR;
        case (op_q)
            OP_NOT, OP_OR, OP_AND, OP_XOR,
            OP_SHR, OP_SHL, OP_ROTR, OP_ROTL,
            OP_ADD, OP_SUB: dec_cls = CLS_WR;
            OP_ADDC, OP_SUBC: dec_cupd = 1'b1;
            OP_INC: begin
                dec_instr = OP_ADD;
                dec_b_one = 1'b1;
            end
            OP_DEC: begin
                dec_instr = OP_SUB;
                dec_b_one = 1'b1;
            end
            OP_SWAP: dec_cls = CLS_SWAP;
            OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET: begin
                dec_instr = OP_SUB;
                dec_cls   = CLS_CMP;
            end
            default: dec_cls = CLS_ILL;
        endcase
    end

    // Datapath and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cy_q      <= 1'b0;
            cls_q     <= CLS_WR;
            cupd_q    <= 1'b0;
            alu_instr <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        rd_q <= req_rd;
                        rs_q <= req_rs;
                    end
                end
                S_DECODE: begin
                    a_q    <= rf[rd_q];
                    b_q    <= rf[rs_q];
                    cls_q  <= dec_cls;
                    cupd_q <= dec_cupd;
                    // SWAP and illegal opcodes leave the ALU drive untouched
                    if (dec_cls == CLS_WR || dec_cls == CLS_CMP) begin
                        alu_instr <= dec_instr;
                        alu_a     <= rf[rd_q];
                        alu_b     <= dec_b_one ? DATA_W'(1) : rf[rs_q];
                    end
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    cy_q  <= alu_carry;
                end
                S_WB: begin
                    case (cls_q)
                        CLS_WR: begin
                            rf[rd_q] <= res_q;
                            flag_z   <= (res_q == '0);
                            flag_n   <= res_q[DATA_W-1];
                            if (cupd_q) begin
                                flag_c <= cy_q;
                            end
                        end
                        CLS_SWAP: begin
                            // rd==rs writes the same value twice: no change
                            rf[rd_q] <= b_q;
                            rf[rs_q] <= a_q;
                        end
                        CLS_CMP: begin
                            case (op_q)
                                OP_EQ: flag_z <= (a_q == b_q);
                                OP_GT: flag_n <= (a_q > b_q);
                                OP_LT: flag_n <= (a_q < b_q);
                                OP_GET: begin
                                    flag_z <= (a_q >= b_q);
                                    flag_n <= !(a_q >= b_q);
                                end
                                OP_LET: begin
                                    flag_z <= (a_q <= b_q);
                                    flag_n <= (a_q <= b_q);
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int DW = 20;
    localparam int OW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_op;
    logic [2:0]    req_rd, req_rs;
    logic [OW-1:0] alu_instr;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_carry;
    logic          done, err, flag_z, flag_n, flag_c;
    logic [2:0]    dbg_addr, mon_addr, stim_addr;
    logic [DW-1:0] dbg_data;
    logic          force_c;
    logic          mon_busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_addr = mon_busy ? mon_addr : stim_addr;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .done(done), .err(err),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: native operations only
    logic stub_c;
    always_comb begin
        alu_result = '0;
        stub_c     = 1'b0;
        case (alu_instr)
            14'h0A7: alu_result = ~alu_a;
            14'h0D1: alu_result = alu_a | alu_b;
            14'h0BC: alu_result = alu_a & alu_b;
            14'h0E6: alu_result = alu_a ^ alu_b;
            14'h0FB: alu_result = alu_a >> 1;
            14'h110: alu_result = alu_a << 1;
            14'h125: alu_result = {alu_a[0], alu_a[DW-1:1]};
            14'h13A: alu_result = {alu_a[DW-2:0], alu_a[DW-1]};
            14'h18E, 14'h1A3: {stub_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            14'h1B8, 14'h1CD: begin
                alu_result = alu_a - alu_b;
                stub_c     = (alu_a < alu_b);
            end
            default: ;
        endcase
        alu_carry = stub_c | force_c;
    end

    // Reference model
    typedef struct packed {
        logic          err;
        logic          z, n, c;
        logic [2:0]    rd, rs;
        logic [DW-1:0] vrd, vrs;
        logic [31:0]   acc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m [8];
    logic          mz, mn, mc;

    int n_chk  = 0;
    int n_fail = 0;
    int last_acc = 0;
    bit b2b_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_op(input logic [13:0] op, input logic [2:0] rd, input logic [2:0] rs);
        exp_t          e;
        logic [DW-1:0] a, b, r;
        logic [DW:0]   s;
        bit            wr;
        e  = '0;
        wr = 0;
        r  = '0;
        a  = m[rd];
        b  = m[rs];
        case (op)
            14'h0A7: begin r = ~a; wr = 1; end
            14'h0D1: begin r = a | b; wr = 1; end
            14'h0BC: begin r = a & b; wr = 1; end
            14'h0E6: begin r = a ^ b; wr = 1; end
            14'h0FB: begin r = a >> 1; wr = 1; end
            14'h110: begin r = a << 1; wr = 1; end
            14'h125: begin r = {a[0], a[DW-1:1]}; wr = 1; end
            14'h13A: begin r = {a[DW-2:0], a[DW-1]}; wr = 1; end
            14'h18E: begin r = a + b; wr = 1; end
            14'h1A3: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[DW-1:0]; wr = 1; mc = s[DW] | force_c;
            end
            14'h1B8: begin r = a - b; wr = 1; end
            14'h1CD: begin r = a - b; wr = 1; mc = (a < b) | force_c; end
            14'h164: begin r = a + 1; wr = 1; end
            14'h179: begin r = a - 1; wr = 1; end
            14'h14F: begin m[rd] = b; m[rs] = a; end
            14'h1E2: mz = (a == b);
            14'h1F7: mn = (a > b);
            14'h20C: mn = (a < b);
            14'h221: begin mz = (a >= b); mn = (a < b); end
            14'h236: begin mz = (a <= b); mn = (a <= b); end
            default: e.err = 1'b1;
        endcase
        if (wr) begin
            m[rd] = r;
            mz    = (r == 0);
            mn    = r[DW-1];
        end
        e.z   = mz;
        e.n   = mn;
        e.c   = mc;
        e.rd  = rd;
        e.rs  = rs;
        e.vrd = m[rd];
        e.vrs = m[rs];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '0;
        mz = 0; mn = 0; mc = 0;
        q.delete();
    endtask

    // Issue one request and hold req_valid through the busy cycles so a
    // stale request must not be accepted twice.
    task automatic issue(input logic [13:0] op, input logic [2:0] rd, input logic [2:0] rs);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs    = rs;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        if (b2b_ok) chk("back2back_accept_gap", cyc + 1 - last_acc, 4);
        e     = model_op(op, rd, rs);
        e.acc = cyc + 1;
        q.push_back(e);
        last_acc = cyc + 1;
        b2b_ok   = 1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || mon_busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        repeat (4) @(negedge clk);
        b2b_ok = 0;
    endtask

    task automatic check_reg(input logic [2:0] idx, input logic [DW-1:0] exp);
        stim_addr = idx;
        #1;
        chk($sformatf("reg_r%0d", idx), dbg_data, exp);
    endtask

    // Monitor: pops on every done pulse
    initial begin
        exp_t e;
        mon_busy = 1'b0;
        mon_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = q.pop_front();
                    mon_busy = 1'b1;
                    chk("err", err, e.err);
                    // WB is the third cycle after the accept edge
                    chk("done_latency", cyc - e.acc, 2);
                    @(negedge clk);
                    chk("flag_z", flag_z, e.z);
                    chk("flag_n", flag_n, e.n);
                    chk("flag_c", flag_c, e.c);
                    mon_addr = e.rd;
                    #1 chk("wb_reg_rd", dbg_data, e.vrd);
                    mon_addr = e.rs;
                    #1 chk("wb_reg_rs", dbg_data, e.vrs);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded limit 300000", $time);
        $fatal(1);
    end

    logic [13:0] ops [21] = '{14'h0A7, 14'h0D1, 14'h0BC, 14'h0E6, 14'h0FB, 14'h110, 14'h125,
                              14'h13A, 14'h14F, 14'h164, 14'h179, 14'h18E, 14'h1A3, 14'h1B8,
                              14'h1CD, 14'h1E2, 14'h1F7, 14'h20C, 14'h221, 14'h236, 14'h000};

    task automatic random_ops(input int n);
        logic [13:0] op;
        for (int k = 0; k < n; k++) begin
            op = ops[$urandom_range(0, 20)];
            if ($urandom_range(0, 9) == 0) op = 14'($urandom);
            force_c = ($urandom_range(0, 3) == 0);
            issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        drain();
        force_c = 1'b0;
    endtask

    initial begin
        logic c_before;
        req_valid = 0; req_op = '0; req_rd = '0; req_rs = '0;
        stim_addr = '0; force_c = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_instr", alu_instr, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
        rst_n = 1'b1;
        #1 chk("rst_req_ready", req_ready, 1);
        for (int i = 0; i < 8; i++) check_reg(3'(i), '0);

        // ADD with carry into bit 16
        issue(14'h0A7, 3'd1, 3'd1);
        repeat (4) issue(14'h0FB, 3'd1, 3'd1);
        issue(14'h164, 3'd2, 3'd2);
        issue(14'h18E, 3'd1, 3'd2);
        drain();
        check_reg(3'd1, 20'h10000);
        chk("add_zn", {flag_z, flag_n}, 2'b00);

        // INC wraps to zero, DEC wraps back
        issue(14'h0A7, 3'd3, 3'd3);
        issue(14'h164, 3'd3, 3'd3);
        drain();
        check_reg(3'd3, 20'h00000);
        chk("inc_wrap_z", flag_z, 1);
        issue(14'h179, 3'd3, 3'd3);
        drain();
        check_reg(3'd3, 20'hFFFFF);
        chk("dec_wrap_n", flag_n, 1);

        // r4=5, r5=9, SWAP, then GET
        issue(14'h164, 3'd4, 3'd4); issue(14'h110, 3'd4, 3'd4);
        issue(14'h110, 3'd4, 3'd4); issue(14'h164, 3'd4, 3'd4);
        issue(14'h164, 3'd5, 3'd5); issue(14'h110, 3'd5, 3'd5);
        issue(14'h110, 3'd5, 3'd5); issue(14'h110, 3'd5, 3'd5);
        issue(14'h164, 3'd5, 3'd5);
        issue(14'h14F, 3'd4, 3'd5);
        drain();
        check_reg(3'd4, 20'd9);
        check_reg(3'd5, 20'd5);
        c_before = flag_c;
        issue(14'h221, 3'd4, 3'd5);
        issue(14'h14F, 3'd6, 3'd6);
        drain();
        chk("get_zn", {flag_z, flag_n}, 2'b10);
        chk("get_c_kept", flag_c, c_before);
        check_reg(3'd4, 20'd9);
        check_reg(3'd5, 20'd5);

        // ADDC with forced carry, AND leaves C alone
        force_c = 1'b1;
        issue(14'h1A3, 3'd6, 3'd6);
        drain();
        force_c = 1'b0;
        chk("addc_c", flag_c, 1);
        issue(14'h0BC, 3'd4, 3'd5);
        drain();
        chk("and_c_kept", flag_c, 1);

        // Illegal opcodes back to back
        issue(14'h0000, 3'd1, 3'd2);
        issue(14'h0000, 3'd4, 3'd5);
        issue(14'h3FFF, 3'd3, 3'd3);
        drain();

        random_ops(60);

        // Reset while ADD r1,r2 is in EXEC
        @(negedge clk);
        req_valid = 1'b1; req_op = 14'h18E; req_rd = 3'd1; req_rs = 3'd2;
        begin
            int w;
            w = 0;
            while (!req_ready && w < 20) begin @(negedge clk); w++; end
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_flags", {flag_z, flag_n, flag_c}, 0);
        chk("abort_alu_instr", alu_instr, 0);
        chk("abort_alu_a", alu_a, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_req_ready", req_ready, 1);
        check_reg(3'd1, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        b2b_ok = 0;

        random_ops(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
